// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit for the EX stage.
// Computes MULT/MULTU/DIV/DIVU with a fixed latency and handles MTHI/MTLO
// in a single cycle. It is the sole producer for the HI/LO write port.
//
// Ports:
//   clk      - system clock, rising edge active
//   reset    - asynchronous active-low reset
//   start    - one-cycle request, sampled on the rising edge
//   op       - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, else no-op
//   a, b     - operands (rs, rt)
//   busy     - high while a mult/div is in flight, including the issuing cycle
//   hiwrite  - one-cycle HI write strobe
//   lowrite  - one-cycle LO write strobe
//   hidata   - value for HI
//   lodata   - value for LO
module mul_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        hiwrite,
   output logic        lowrite,
   output logic [31:0] hidata,
   output logic [31:0] lodata
);

   localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
   localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   // op_q[1]: divide, op_q[0]: unsigned
   logic [1:0]  op_q, op_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        hiwr_q, hiwr_d;
   logic        lowr_q, lowr_d;

   // Arithmetic on the latched operands
   logic [63:0] prod_s, prod_u;
   logic        div_signed;
   logic [31:0] dvd, dvs, quo, rem, quo_res, rem_res;

   always_comb begin
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u = {32'd0, a_q} * {32'd0, b_q};

      // Signed divide goes through magnitudes, then the signs are restored:
      // quotient negative when signs differ, remainder follows the dividend.
      div_signed = ~op_q[0];
      dvd = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
      dvs = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
      quo = (dvs != 32'd0) ? (dvd / dvs) : 32'd0;
      rem = (dvs != 32'd0) ? (dvd % dvs) : 32'd0;
      quo_res = (div_signed && (a_q[31] ^ b_q[31])) ? (~quo + 32'd1) : quo;
      rem_res = (div_signed && a_q[31]) ? (~rem + 32'd1) : rem;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hiwr_d  = 1'b0;
      lowr_d  = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               if (!op[2]) begin
                  a_d     = a;
                  b_d     = b;
                  op_d    = op[1:0];
                  cnt_d   = op[1] ? DivCnt : MultCnt;
                  state_d = StBusy;
               end else if (op[1:0] == 2'b00) begin
                  hi_d   = a;
                  hiwr_d = 1'b1;
               end else if (op[1:0] == 2'b01) begin
                  lo_d   = a;
                  lowr_d = 1'b1;
               end
            end
         end
         StBusy: begin
            // start is ignored here; the pipeline holds the instruction under busy
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StIdle;
               if (!op_q[1]) begin
                  {hi_d, lo_d} = op_q[0] ? prod_u : prod_s;
                  hiwr_d = 1'b1;
                  lowr_d = 1'b1;
               end else if (b_q != 32'd0) begin
                  // Divide by zero leaves HI/LO untouched and raises no strobe
                  hi_d   = rem_res;
                  lo_d   = quo_res;
                  hiwr_d = 1'b1;
                  lowr_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= 2'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         hiwr_q  <= 1'b0;
         lowr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hiwr_q  <= hiwr_d;
         lowr_q  <= lowr_d;
      end
   end

   // Combinational so the issuing cycle already stalls dependent instructions
   assign busy    = (state_q == StBusy) | ((state_q == StIdle) & start & ~op[2]);
   assign hiwrite = hiwr_q;
   assign lowrite = lowr_q;
   assign hidata  = hi_q;
   assign lodata  = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected HI/LO writes are queued with
// their due cycle when an op is issued, and compared when that cycle arrives.
module tb_mul_div_unit;

   localparam logic [2:0] OpMult  = 3'b000;
   localparam logic [2:0] OpMultu = 3'b001;
   localparam logic [2:0] OpDiv   = 3'b010;
   localparam logic [2:0] OpDivu  = 3'b011;
   localparam logic [2:0] OpMthi  = 3'b100;
   localparam logic [2:0] OpMtlo  = 3'b101;
   localparam logic [2:0] OpNop   = 3'b110;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, hiwrite, lowrite;
   logic [31:0] hidata, lodata;

   mul_div_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .hiwrite(hiwrite),
      .lowrite(lowrite),
      .hidata (hidata),
      .lodata (lodata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        hw;
      logic        lw;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference arithmetic, done with wide native SV operators
   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output bit wr_h, output bit wr_l,
                        output logic [31:0] hi_e, output logic [31:0] lo_e);
      longint      ps, q, r;
      logic [63:0] pu;
      wr_h = 1'b0;
      wr_l = 1'b0;
      hi_e = hi_m;
      lo_e = lo_m;
      case (o)
         OpMult: begin
            ps = longint'($signed(x)) * longint'($signed(y));
            hi_e = ps[63:32]; lo_e = ps[31:0]; wr_h = 1'b1; wr_l = 1'b1;
         end
         OpMultu: begin
            pu = 64'(x) * 64'(y);
            hi_e = pu[63:32]; lo_e = pu[31:0]; wr_h = 1'b1; wr_l = 1'b1;
         end
         OpDiv: if (y != 0) begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
            hi_e = r[31:0]; lo_e = q[31:0]; wr_h = 1'b1; wr_l = 1'b1;
         end
         OpDivu: if (y != 0) begin
            hi_e = x % y; lo_e = x / y; wr_h = 1'b1; wr_l = 1'b1;
         end
         OpMthi: begin hi_e = x; wr_h = 1'b1; end
         OpMtlo: begin lo_e = x; wr_l = 1'b1; end
         default: ;
      endcase
   endtask

   // Issue one op from IDLE and walk it to completion, checking busy each cycle.
   // With inject set, MTHI, DIV and a final-edge MULTU are pulsed while busy.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject);
      int          n;
      bit          wr_h, wr_l;
      logic [31:0] hi_e, lo_e;
      exp_t        e;
      model(o, x, y, wr_h, wr_l, hi_e, lo_e);
      n = o[2] ? 0 : (o[1] ? 10 : 5);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (wr_h || wr_l) begin
         hi_m = hi_e;
         lo_m = lo_e;
         e.cyc = cyc + 1 + n; e.hw = wr_h; e.lw = wr_l; e.hi = hi_m; e.lo = lo_m;
         sb_q.push_back(e);
      end
      #1 check_eq("busy_issue", 64'(busy), 64'(!o[2]));
      @(posedge clk);
      #1 start = 1'b0; a = $urandom; b = $urandom;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (inject) begin
            start = (i == 0) || (i == 1) || (i == n - 1);
            op = (i == 0) ? OpMthi : ((i == 1) ? OpDiv : OpMultu);
            a = 32'hDEADBEEF; b = 32'h00000001;
         end else begin
            a = $urandom; b = $urandom;
         end
         #1 check_eq("busy_inflight", 64'(busy), 64'd1);
      end
      @(negedge clk);
      start = 1'b0;
      #1 check_eq("busy_done", 64'(busy), 64'd0);
      check_eq("hidata_hold", 64'(hidata), 64'(hi_m));
      check_eq("lodata_hold", 64'(lodata), 64'(lo_m));
   endtask

   // Scoreboard: compare the due entry, otherwise any strobe is unexpected
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            check_eq("hiwrite", 64'(hiwrite), 64'(e.hw));
            check_eq("lowrite", 64'(lowrite), 64'(e.lw));
            check_eq("hidata", 64'(hidata), 64'(e.hi));
            check_eq("lodata", 64'(lodata), 64'(e.lo));
         end else if (hiwrite || lowrite) begin
            check_eq("spurious_strobe", {62'd0, hiwrite, lowrite}, 64'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x, y;
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_strobes", {62'd0, hiwrite, lowrite}, 64'd0);
      check_eq("rst_hidata", 64'(hidata), 64'd0);
      check_eq("rst_lodata", 64'(lodata), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Directed vectors
      issue(OpMult,  32'hFFFFFFFE, 32'h00000003, 1'b0);
      issue(OpMultu, 32'hFFFFFFFE, 32'h00000003, 1'b0);
      issue(OpDiv,   32'hFFFFFFF9, 32'h00000002, 1'b0);
      issue(OpDivu,  32'h00000007, 32'h00000002, 1'b0);
      issue(OpDiv,   32'h80000000, 32'hFFFFFFFF, 1'b0);
      issue(OpMthi,  32'h12345678, 32'h0, 1'b0);
      issue(OpMtlo,  32'hCAFEBABE, 32'h0, 1'b0);
      issue(OpNop,   32'h55555555, 32'h0, 1'b0);
      issue(3'b111,  32'hAAAAAAAA, 32'h0, 1'b0);

      // Starts while busy are ignored; only the MULT result is written
      issue(OpMult,  32'h00001234, 32'hFFFF0000, 1'b1);

      // Divide by zero: full busy time, no strobe, HI/LO held
      issue(OpDiv,   32'h00000064, 32'h00000000, 1'b0);
      issue(OpDivu,  32'hFFFFFFFF, 32'h00000000, 1'b0);

      // Random operands against the reference model
      for (int k = 0; k < 4; k++) begin
         for (int o = 0; o < 4; o++) begin
            x = $urandom;
            y = (k == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (y == 0) y = 32'd1;
            issue(3'(o), x, y, 1'b0);
         end
      end

      // Asynchronous reset in the 3rd cycle of a DIV discards it
      @(negedge clk);
      start = 1'b1; op = OpDiv; a = 32'd100; b = 32'd7;
      #1 check_eq("busy_issue_rst", 64'(busy), 64'd1);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_strobes", {62'd0, hiwrite, lowrite}, 64'd0);
      check_eq("arst_hidata", 64'(hidata), 64'd0);
      check_eq("arst_lodata", 64'(lodata), 64'd0);
      hi_m = 32'd0;
      lo_m = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      #1 check_eq("post_rst_busy", 64'(busy), 64'd0);
      issue(OpMult, 32'h00000007, 32'hFFFFFFFA, 1'b0);

      repeat (3) @(negedge clk);
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multiply/divide unit in the EX stage of the pipelined MIPS core. It takes a start pulse, an operation code and two 32-bit operands, and computes mult/multu/div/divu over a fixed multi-cycle latency. It also handles mthi/mtlo in a single cycle. It is the producer for the register file's HI/LO write port: it drives hidata/lodata with hiwrite/lowrite pulses, and drives busy back to hazard control so that dependent HI/LO instructions stall.

Parameters:
MULT_CYCLES, 5, number of busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, number of busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
start  input  1  one-cycle request; sampled on the rising edge of clk
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
a  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
b  input  32  operand rt (divisor / multiplier)
busy  output  1  high while a mult/div is in flight, including the start cycle
hiwrite  output  1  one-cycle write strobe for HI
lowrite  output  1  one-cycle write strobe for LO
hidata  output  32  value to be written to HI
lodata  output  32  value to be written to LO

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, latched operands=0, hiwrite=lowrite=0, hidata=lodata=0. An in-flight operation is discarded and no strobe is ever produced for it.
- State machine has two states, IDLE and BUSY.
- IDLE, start=1, op in MULT..DIVU, sampled at edge E0:
  - latch a, b and op.
  - counter <= MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY: counter decrements once per edge. On the edge where counter==1:
  - go to IDLE.
  - register the results into hidata/lodata.
  - set hiwrite=lowrite=1 for exactly one cycle.
- Latency: strobes are high in the cycle following edge E0+N, where N is the cycle count for the op. The register file commits on edge E0+N+1 and bypasses HI/LO during the strobe cycle.
- busy = (state==BUSY) | (state==IDLE & start & op in MULT..DIVU). busy is combinational so that the issuing cycle already stalls. busy is low during the strobe cycle.
- IDLE, start=1, op=MTHI: at E0, hidata<=a and hiwrite=1 for one cycle. lowrite stays 0 and lodata holds its value. No BUSY state is entered.
- IDLE, start=1, op=MTLO: same as MTHI, applied to lodata/lowrite.
- Strobes are 0 in every cycle not listed above.
- start while BUSY (any op), including on the final BUSY edge: ignored. The latched operands are unchanged and no extra strobe is produced. The pipeline must hold the instruction under busy.
- op 110/111 with start=1: no effect.
- Arithmetic:
  - MULT: 64-bit two's-complement product of a and b; hidata = [63:32], lodata = [31:0].
  - MULTU: unsigned 64-bit product, same split.
  - DIV: signed; lodata = quotient truncated toward zero; hidata = remainder with the sign of the dividend.
  - DIVU: unsigned quotient (lodata) and remainder (hidata).
  - DIV 0x80000000 / 0xFFFFFFFF: lodata=0x80000000, hidata=0.
- Divide by zero (b==0, DIV/DIVU): full DIV_CYCLES busy time. At completion hiwrite=lowrite=0, so HI/LO keep their previous values. hidata/lodata are unchanged.
- Results depend only on the operands latched at E0. Changes on a/b during BUSY have no effect.
- Implementation may compute with behavioural * and / in the completion cycle or iteratively. Only the outputs and timing above are observable.

Test Plan:
- MULT a=0xFFFFFFFE, b=0x00000003:
  - busy=1 in the start cycle and for 5 cycles after.
  - Then one cycle with hiwrite=lowrite=1, hidata=0xFFFFFFFF, lodata=0xFFFFFFFA.
- MULTU with the same operands -> hidata=0x00000002, lodata=0xFFFFFFFA after 5 busy cycles.
- DIV a=0xFFFFFFF9 (-7), b=2:
  - after 10 busy cycles, lodata=0xFFFFFFFD, hidata=0xFFFFFFFF.
  - DIVU 7/2 -> lodata=3, hidata=1.
  - DIV 0x80000000 / 0xFFFFFFFF -> lodata=0x80000000, hidata=0.
- MTHI a=0x12345678 in IDLE:
  - next cycle hiwrite=1, hidata=0x12345678, lowrite=0, busy never high.
  - MTLO a=0xCAFEBABE -> lowrite pulse, hidata still 0x12345678.
- Start a MULT, then pulse start with MTHI and then DIV during BUSY -> both ignored; exactly one strobe, carrying the MULT result. DIV with b=0 -> 10 busy cycles, then no strobe.
- Drive reset=0 asynchronously (between clock edges) at the 3rd cycle of a DIV -> busy, strobes and data go to 0 immediately; after release no strobe ever appears and the next MULT behaves normally.
